// File: rtl/muti_cycle.sv
// Iterative 32-step multiply/divide unit with private HI/LO registers for the MIPS ALU stage.
// Shift-add multiply and restoring divide run on operand magnitudes; the sign is fixed up on the last step.
module muti_cycle (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [4:0]  aluop,
    input  logic [31:0] aluA,
    input  logic [31:0] aluB,
    output logic [31:0] hiOut,
    output logic [31:0] loOut,
    output logic        finish
);
    // state | meaning
    // IDLE  | waiting for MULT/MULTU/DIV/DIVU; MTHI/MTLO write HI/LO here only
    // BUSY  | one radix-2 step per clock, 32 steps, HI/LO written on the last
    // DONE  | finish high for this single cycle, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_MTHI = 5'b01001;
    localparam logic [4:0] OP_MTLO = 5'b01011;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] a_q, a_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        finish_q, finish_d;

    logic        is_md;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // 01100..01111 are the four mult/div ops; bit 0 clear selects the signed form
    assign is_md = (aluop[4:2] == 3'b011);
    assign a_neg = ~aluop[0] & aluA[31];
    assign b_neg = ~aluop[0] & aluB[31];
    assign a_mag = a_neg ? (~aluA + 32'd1) : aluA;
    assign b_mag = b_neg ? (~aluB + 32'd1) : aluB;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] trial;
    logic [33:0] diff;
    logic [63:0] div_next;
    logic [63:0] step_res;
    logic [63:0] prod_fix;
    logic [31:0] quo, rem;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign trial    = {acc_q[63:32], acc_q[31]};
    assign diff     = {1'b0, trial} - {2'b00, opnd_q};
    assign div_next = diff[33] ? {trial[31:0], acc_q[30:0], 1'b0}
                               : {diff[31:0],  acc_q[30:0], 1'b1};

    assign step_res = is_div_q ? div_next : mul_next;
    assign prod_fix = neg_res_q ? (~step_res + 64'd1) : step_res;
    assign quo      = neg_res_q ? (~step_res[31:0] + 32'd1) : step_res[31:0];
    assign rem      = neg_rem_q ? (~step_res[63:32] + 32'd1) : step_res[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        finish_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (aluop == OP_MTHI) hi_d = aluA;
                if (aluop == OP_MTLO) lo_d = aluA;
                if (start && is_md) begin
                    is_div_d  = aluop[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    a_d       = aluA;
                    opnd_d    = aluop[1] ? b_mag : a_mag;
                    acc_d     = {32'd0, (aluop[1] ? a_mag : b_mag)};
                    cnt_d     = 5'd0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                acc_d = step_res;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (opnd_q == 32'd0) begin
                        // divide by zero reports the raw dividend, not its magnitude
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            a_q       <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            finish_q  <= finish_d;
        end
    end

    assign hiOut  = hi_q;
    assign loOut  = lo_q;
    assign finish = finish_q;
endmodule

// File: tb/tb_muti_cycle.sv
// Bench for muti_cycle: directed and random mult/div ops against 64-bit arithmetic reference,
// plus MTHI/MTLO, handshake timing and asynchronous reset behaviour.
module tb_muti_cycle;
    localparam logic [4:0] OP_MULT  = 5'b01100;
    localparam logic [4:0] OP_MULTU = 5'b01101;
    localparam logic [4:0] OP_DIV   = 5'b01110;
    localparam logic [4:0] OP_DIVU  = 5'b01111;
    localparam logic [4:0] OP_MTHI  = 5'b01001;
    localparam logic [4:0] OP_MTLO  = 5'b01011;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [4:0]  aluop;
    logic [31:0] aluA, aluB;
    logic [31:0] hiOut, loOut;
    logic        finish;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    muti_cycle dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .aluop  (aluop),
        .aluA   (aluA),
        .aluB   (aluB),
        .hiOut  (hiOut),
        .loOut  (loOut),
        .finish (finish)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results straight from signed/unsigned integer arithmetic.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            OP_MULT: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = 32'(q);
                    hi = 32'(r);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Called #1 after an edge in IDLE. Drives start = !finish (unless hold keeps start high),
    // optionally disturbs operands and issues MTHI during BUSY.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb, input bit hold);
        logic [31:0] eh, el;
        int          n;
        bit          got;
        model(op, a, b, eh, el);
        start = 1'b1;
        aluop = op;
        aluA  = a;
        aluB  = b;
        n     = 0;
        got   = 1'b0;
        while (n < 40 && !got) begin
            @(posedge CLK);
            #1;
            n++;
            if (disturb && n == 5) begin
                aluA  = $urandom;
                aluB  = $urandom;
                aluop = OP_MTHI;
            end
            if (n == 32) begin
                chk({tag, " hold hi"}, hiOut, hi_m);
                chk({tag, " hold lo"}, loOut, lo_m);
            end
            got = finish;
            if (!hold) start = !finish;
        end
        chk({tag, " latency"}, 32'(n), 32'd33);
        chk({tag, " hi"}, hiOut, eh);
        chk({tag, " lo"}, loOut, el);
        hi_m = eh;
        lo_m = el;
        if (!hold) aluop = 5'd0;
        @(posedge CLK);
        #1;
        chk({tag, " finish single"}, {31'd0, finish}, 32'd0);
    endtask

    task automatic mt(input string tag, input logic [4:0] op, input logic [31:0] v);
        start = 1'b0;
        aluop = op;
        aluA  = v;
        @(posedge CLK);
        #1;
        if (op == OP_MTHI) hi_m = v;
        else lo_m = v;
        aluop = 5'd0;
        chk({tag, " hi"}, hiOut, hi_m);
        chk({tag, " lo"}, loOut, lo_m);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        bit          seen;

        RST   = 1'b1;
        start = 1'b0;
        aluop = 5'd0;
        aluA  = 32'd0;
        aluB  = 32'd0;
        #12;
        chk("reset hi", hiOut, 32'd0);
        chk("reset lo", loOut, 32'd0);
        chk("reset finish", {31'd0, finish}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        mt("mthi", OP_MTHI, 32'h1234_5678);
        mt("mtlo", OP_MTLO, 32'hCAFE_F00D);

        do_op("mult -2x3",   OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
        do_op("multu",       OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
        do_op("div -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        do_op("divu 100/7",  OP_DIVU,  32'd100,       32'd7,         1'b0, 1'b0);
        do_op("divu 5/0",    OP_DIVU,  32'd5,         32'd0,         1'b0, 1'b0);
        do_op("div min/-1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("div -9/0",    OP_DIV,   32'hFFFF_FFF7, 32'd0,         1'b0, 1'b0);
        do_op("mult disturb", OP_MULT, 32'h8765_4321, 32'hFEDC_BA98, 1'b1, 1'b0);

        // start held high through DONE: second op must wait for the IDLE cycle
        do_op("b2b first",  OP_MULT, 32'h0001_0003, 32'hFFFF_0007, 1'b0, 1'b1);
        do_op("b2b second", OP_MULT, 32'h0001_0003, 32'hFFFF_0007, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rop = 5'(5'd12 + 5'($urandom_range(0, 3)));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op("random", rop, ra, rb, 1'b0, 1'b0);
        end

        seen = 1'b0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            if (finish) seen = 1'b1;
        end
        chk("idle no finish", {31'd0, seen}, 32'd0);

        // asynchronous reset in the middle of an operation
        mt("pre-reset mthi", OP_MTHI, 32'h1111_1111);
        start = 1'b1;
        aluop = OP_MULT;
        aluA  = 32'd3;
        aluB  = 32'd5;
        repeat (10) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("midop reset hi", hiOut, 32'd0);
        chk("midop reset lo", loOut, 32'd0);
        chk("midop reset finish", {31'd0, finish}, 32'd0);
        start = 1'b0;
        aluop = 5'd0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        @(posedge CLK);
        #1;
        RST  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (finish) seen = 1'b1;
        end
        chk("no finish after reset", {31'd0, seen}, 32'd0);
        chk("post-reset hi", hiOut, hi_m);

        do_op("after reset", OP_DIVU, 32'd1000, 32'd33, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
